// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I decode into ALU control/operands, held in a
// registered ID/EX slot with valid/ready handshake, stall and flush.
// All ex_* outputs come straight from flops; decode is purely on the input side.
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [3:0]      ex_alu_ctrl,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [1:0]      ex_res_sel,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write,
  output logic            ex_branch,
  output logic [2:0]      ex_funct3,
  output logic [XLEN-1:0] ex_pc,
  output logic            ex_illegal
);

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SLL = 4'b1010;
  localparam logic [3:0] ALU_SRA = 4'b1100;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_LT  = 2'b01;
  localparam logic [1:0] RES_LTU = 2'b10;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Shared R/I funct3 -> ALU op; 'alt' selects SUB/SRA over ADD/SRL.
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SUB;
      3'b011:  op = ALU_SUB;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Set-less-than variants route the ALU flags instead of the result.
  function automatic logic [1:0] res_of(input logic [2:0] f3);
    logic [1:0] rs;
    case (f3)
      3'b010:  rs = RES_LT;
      3'b011:  rs = RES_LTU;
      default: rs = RES_ALU;
    endcase
    return rs;
  endfunction

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [4:0]      w_rd;
  logic            w_f7_zero;
  logic            w_f7_alt;
  logic            w_is_shift;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_u;

  logic [3:0]      w_ctrl;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [1:0]      w_res_sel;
  logic            w_branch;
  logic            w_illegal;
  logic            w_writer;
  logic            w_reg_write;
  logic            w_capture;

  assign w_opcode   = instr[6:0];
  assign w_rd       = instr[11:7];
  assign w_funct3   = instr[14:12];
  assign w_funct7   = instr[31:25];
  assign w_f7_zero  = (w_funct7 == F7_ZERO);
  assign w_f7_alt   = (w_funct7 == F7_ALT);
  assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);
  assign w_imm_i    = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign w_imm_u    = {instr[31:12], 12'b0};

  // Decode the offered instruction into ALU control and operand words.
  always_comb begin
    w_ctrl    = ALU_ADD;
    w_a       = rs1_data;
    w_b       = rs2_data;
    w_res_sel = RES_ALU;
    w_branch  = 1'b0;
    w_illegal = 1'b0;
    w_writer  = 1'b0;
    case (w_opcode)
      OP_R: begin
        w_writer  = 1'b1;
        w_illegal = !(w_f7_zero ||
                      (w_f7_alt && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))));
        w_ctrl    = alu_op(w_funct3, w_f7_alt);
        w_res_sel = res_of(w_funct3);
        // SRA consumes all of B, so shift amounts must arrive with B[31:5] clear.
        w_b       = w_is_shift ? {{(XLEN-5){1'b0}}, rs2_data[4:0]} : rs2_data;
      end
      OP_I: begin
        w_writer  = 1'b1;
        if (w_funct3 == 3'b001) begin
          w_illegal = !w_f7_zero;
        end else if (w_funct3 == 3'b101) begin
          w_illegal = !(w_f7_zero || w_f7_alt);
        end else begin
          w_illegal = 1'b0;
        end
        // Only shifts read funct7; ADDI with imm[10]=1 must stay ADD.
        w_ctrl    = alu_op(w_funct3, w_is_shift && w_f7_alt);
        w_res_sel = res_of(w_funct3);
        w_b       = w_is_shift ? {{(XLEN-5){1'b0}}, instr[24:20]} : w_imm_i;
      end
      OP_LUI: begin
        w_writer = 1'b1;
        w_a      = '0;
        w_b      = w_imm_u;
      end
      OP_AUIPC: begin
        w_writer = 1'b1;
        w_a      = pc;
        w_b      = w_imm_u;
      end
      OP_BR: begin
        w_ctrl    = ALU_SUB;
        w_branch  = 1'b1;
        w_illegal = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  assign w_reg_write = w_writer && !w_illegal && (w_rd != 5'd0);
  assign id_ready    = !ex_valid || ex_ready;
  assign w_capture   = id_valid && id_ready;

  logic            r_valid;
  logic [3:0]      r_ctrl;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [1:0]      r_res_sel;
  logic [4:0]      r_rd;
  logic            r_reg_write;
  logic            r_branch;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_pc;
  logic            r_illegal;

  // ID/EX slot: flush beats capture, capture beats drain; otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_ctrl      <= ALU_ADD;
      r_a         <= '0;
      r_b         <= '0;
      r_res_sel   <= RES_ALU;
      r_rd        <= 5'd0;
      r_reg_write <= 1'b0;
      r_branch    <= 1'b0;
      r_funct3    <= 3'd0;
      r_pc        <= '0;
      r_illegal   <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid     <= 1'b1;
      // An illegal op issues as a harmless ADD with no side effects.
      r_ctrl      <= w_illegal ? ALU_ADD : w_ctrl;
      r_a         <= w_a;
      r_b         <= w_b;
      r_res_sel   <= w_illegal ? RES_ALU : w_res_sel;
      r_rd        <= w_rd;
      r_reg_write <= w_reg_write;
      r_branch    <= w_branch && !w_illegal;
      r_funct3    <= w_funct3;
      r_pc        <= pc;
      r_illegal   <= w_illegal;
    end else if (r_valid && ex_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign ex_valid     = r_valid;
  assign ex_alu_ctrl  = r_ctrl;
  assign ex_a         = r_a;
  assign ex_b         = r_b;
  assign ex_res_sel   = r_res_sel;
  assign ex_rd        = r_rd;
  assign ex_reg_write = r_reg_write;
  assign ex_branch    = r_branch;
  assign ex_funct3    = r_funct3;
  assign ex_pc        = r_pc;
  assign ex_illegal   = r_illegal;

endmodule
